// File: rtl/fft_stage_ctrl_if.sv
// Bus between the FFT stage sequencer and the RAM / twiddle ROM / butterfly datapath.
// Optional FFT_BITREV_UNLOAD_EN adds the natural-order unload outputs out_valid/out_idx.
interface fft_stage_ctrl_if #(
  parameter int unsigned LOG2N = 5,
  parameter int unsigned DW    = 16
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [LOG2N-1:0]        rd_addr_a;
  logic [LOG2N-1:0]        rd_addr_b;
  logic                    rd_en;
  logic [LOG2N-2:0]        tw_addr;
  logic signed [DW-1:0]    bf_xa_re;
  logic signed [DW-1:0]    bf_xa_im;
  logic signed [DW-1:0]    bf_xb_re;
  logic signed [DW-1:0]    bf_xb_im;
  logic                    wr_en;
  logic [LOG2N-1:0]        wr_addr_a;
  logic [LOG2N-1:0]        wr_addr_b;
  logic signed [DW-1:0]    wr_a_re;
  logic signed [DW-1:0]    wr_a_im;
  logic signed [DW-1:0]    wr_b_re;
  logic signed [DW-1:0]    wr_b_im;
`ifdef FFT_BITREV_UNLOAD_EN
  logic                    out_valid;
  logic [LOG2N-1:0]        out_idx;
`endif

  // Sequencer side
  modport master (
    input  start, bf_xa_re, bf_xa_im, bf_xb_re, bf_xb_im,
    output busy, done, rd_addr_a, rd_addr_b, rd_en, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b, wr_a_re, wr_a_im, wr_b_re, wr_b_im
`ifdef FFT_BITREV_UNLOAD_EN
    , output out_valid, out_idx
`endif
  );

  // Top-level / datapath side
  modport slave (
    output start, bf_xa_re, bf_xa_im, bf_xb_re, bf_xb_im,
    input  busy, done, rd_addr_a, rd_addr_b, rd_en, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b, wr_a_re, wr_a_im, wr_b_re, wr_b_im
`ifdef FFT_BITREV_UNLOAD_EN
    , input out_valid, out_idx
`endif
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIF FFT stage sequencer: one butterfly issued per RUN cycle, two DRAIN
// cycles between stages, writes trail reads by exactly two cycles.
// Optional macro FFT_BITREV_UNLOAD_EN: adds an UNLOAD pass reading bins in natural order.
module fft_stage_ctrl #(
  parameter int unsigned LOG2N = 5,
  parameter int unsigned DW    = 16
) (
  input logic                clk,
  input logic                rst,
  fft_stage_ctrl_if.master   bus_io
);

  localparam int unsigned SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam logic [SW-1:0]    LastStage = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] LastK     = '1;
  localparam logic [LOG2N-1:0] SpanMax   = {1'b1, {(LOG2N-1){1'b0}}};

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
`ifdef FFT_BITREV_UNLOAD_EN
  localparam logic [2:0] StUnload = 3'd4;
  localparam logic [LOG2N-1:0] LastIdx = '1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic             drain_q, drain_d;
`ifdef FFT_BITREV_UNLOAD_EN
  logic [LOG2N-1:0] idx_q, idx_d;
  logic             ov_q;
  logic [LOG2N-1:0] oidx_q;
`endif

  logic [LOG2N-2:0] mask_k, j, hi;
  logic [LOG2N-1:0] span, base;
  logic [LOG2N-1:0] rd_a, rd_b;
  logic [LOG2N-2:0] tw;
  logic             rd;

  // Write-side pipeline: valid and addresses delayed two cycles, Xa delayed one.
  logic                 v1_q, v2_q;
  logic [LOG2N-1:0]     a1_q, b1_q, a2_q, b2_q;
  logic signed [DW-1:0] xa_re_q, xa_im_q;

  // Next-state logic for the stage / butterfly walk
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
`ifdef FFT_BITREV_UNLOAD_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (k_q == LastK) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q) begin
          if (stage_q == LastStage) begin
`ifdef FFT_BITREV_UNLOAD_EN
            state_d = StUnload;
            idx_d   = '0;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StRun;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          drain_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
        k_d     = '0;
      end
`ifdef FFT_BITREV_UNLOAD_EN
      StUnload: begin
        if (idx_q == LastIdx) state_d = StDone;
        else                  idx_d   = idx_q + 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Read address generation: insert a 0 bit at the span position of k to get the A index
  always_comb begin
    mask_k = LastK >> stage_q;
    j      = k_q & mask_k;
    hi     = k_q & ~mask_k;
    span   = SpanMax >> stage_q;
    base   = {hi, 1'b0} | {1'b0, j};
    rd     = 1'b0;
    rd_a   = '0;
    rd_b   = '0;
    tw     = '0;
    if (state_q == StRun) begin
      rd   = 1'b1;
      rd_a = base;
      rd_b = base | span;
      tw   = j << stage_q;
    end
`ifdef FFT_BITREV_UNLOAD_EN
    if (state_q == StUnload) begin
      rd   = 1'b1;
      rd_a = bitrev(idx_q);
    end
`endif
  end

  // FSM and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= 1'b0;
`ifdef FFT_BITREV_UNLOAD_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      drain_q <= drain_d;
`ifdef FFT_BITREV_UNLOAD_EN
      idx_q   <= idx_d;
`endif
    end
  end

  // Write-back alignment pipeline; only RUN reads produce writes
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      xa_re_q <= '0;
      xa_im_q <= '0;
`ifdef FFT_BITREV_UNLOAD_EN
      ov_q    <= 1'b0;
      oidx_q  <= '0;
`endif
    end else begin
      v1_q    <= (state_q == StRun);
      v2_q    <= v1_q;
      a1_q    <= rd_a;
      b1_q    <= rd_b;
      a2_q    <= a1_q;
      b2_q    <= b1_q;
      xa_re_q <= bus_io.bf_xa_re;
      xa_im_q <= bus_io.bf_xa_im;
`ifdef FFT_BITREV_UNLOAD_EN
      ov_q    <= (state_q == StUnload);
      oidx_q  <= idx_q;
`endif
    end
  end

  // Outputs
  always_comb begin
    bus_io.busy      = (state_q == StRun) || (state_q == StDrain)
`ifdef FFT_BITREV_UNLOAD_EN
                       || (state_q == StUnload)
`endif
                       ;
    bus_io.done      = (state_q == StDone);
    bus_io.rd_en     = rd;
    bus_io.rd_addr_a = rd_a;
    bus_io.rd_addr_b = rd_b;
    bus_io.tw_addr   = tw;
    bus_io.wr_en     = v2_q;
    bus_io.wr_addr_a = a2_q;
    bus_io.wr_addr_b = b2_q;
    bus_io.wr_a_re   = xa_re_q;
    bus_io.wr_a_im   = xa_im_q;
    // Xb is passed through but held at zero when no write is pending
    bus_io.wr_b_re   = v2_q ? bus_io.bf_xb_re : '0;
    bus_io.wr_b_im   = v2_q ? bus_io.bf_xb_im : '0;
`ifdef FFT_BITREV_UNLOAD_EN
    bus_io.out_valid = ov_q;
    bus_io.out_idx   = oidx_q;
`endif
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: behavioural RAM, twiddle ROM and saturating butterfly around the
// sequencer; directed timing/address vectors plus an impulse transform.
module tb_fft_stage_ctrl;
  localparam int LOG2N  = 5;
  localparam int DW     = 16;
  localparam int N      = 32;
  localparam int Half   = 16;
  localparam int SegLen = Half + 2;
  localparam int RunEnd = LOG2N * SegLen;  // 90
`ifdef FFT_BITREV_UNLOAD_EN
  localparam int DoneCyc = RunEnd + N + 1; // 123
  localparam int RdTotal = 80 + N;
`else
  localparam int DoneCyc = RunEnd + 1;     // 91
  localparam int RdTotal = 80;
`endif

  logic clk, rst, mem_init;
  fft_stage_ctrl_if #(.LOG2N(LOG2N), .DW(DW)) bus ();
  fft_stage_ctrl #(.LOG2N(LOG2N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- datapath model ----------------
  logic signed [15:0] mem_re [N];
  logic signed [15:0] mem_im [N];
  logic signed [15:0] rom_re [Half];
  logic signed [15:0] rom_im [Half];
  logic signed [15:0] ra_re, ra_im, rb_re, rb_im, w_re, w_im;
  logic signed [15:0] xb_re_q, xb_im_q, xb_re_c, xb_im_c;
  longint d_re, d_im, p_re, p_im;

  function automatic logic signed [15:0] sat16(input longint v);
    if (v > 32767)  return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return v[15:0];
  endfunction

  initial begin
    for (int m = 0; m < Half; m++) begin
      rom_re[m] = 16'($rtoi($floor(16384.0 * $cos(6.283185307179586 * m / N) + 0.5)));
      rom_im[m] = 16'($rtoi($floor(-16384.0 * $sin(6.283185307179586 * m / N) + 0.5)));
    end
  end

  assign bus.bf_xa_re = sat16(longint'(ra_re) + longint'(rb_re));
  assign bus.bf_xa_im = sat16(longint'(ra_im) + longint'(rb_im));
  assign bus.bf_xb_re = xb_re_q;
  assign bus.bf_xb_im = xb_im_q;

  always_comb begin
    d_re = longint'(sat16(longint'(ra_re) - longint'(rb_re)));
    d_im = longint'(sat16(longint'(ra_im) - longint'(rb_im)));
    p_re = (d_re * longint'(w_re) - d_im * longint'(w_im) + 8192) >>> 14;
    p_im = (d_re * longint'(w_im) + d_im * longint'(w_re) + 8192) >>> 14;
    xb_re_c = sat16(p_re);
    xb_im_c = sat16(p_im);
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) begin
        mem_re[i] <= (i == 0) ? 16'sd1000 : 16'sd0;
        mem_im[i] <= 16'sd0;
      end
      ra_re <= '0; ra_im <= '0; rb_re <= '0; rb_im <= '0;
      xb_re_q <= '0; xb_im_q <= '0; w_re <= '0; w_im <= '0;
    end else begin
      if (bus.rd_en) begin
        ra_re <= mem_re[bus.rd_addr_a];
        ra_im <= mem_im[bus.rd_addr_a];
        rb_re <= mem_re[bus.rd_addr_b];
        rb_im <= mem_im[bus.rd_addr_b];
      end
      w_re    <= rom_re[bus.tw_addr];
      w_im    <= rom_im[bus.tw_addr];
      xb_re_q <= xb_re_c;
      xb_im_q <= xb_im_c;
      if (bus.wr_en) begin
        mem_re[bus.wr_addr_a] <= bus.wr_a_re;
        mem_im[bus.wr_addr_a] <= bus.wr_a_im;
        mem_re[bus.wr_addr_b] <= bus.wr_b_re;
        mem_im[bus.wr_addr_b] <= bus.wr_b_im;
      end
    end
  end

  // ---------------- reference schedule ----------------
  function automatic bit exp_run(input int c);
    if (c < 1 || c > RunEnd) return 1'b0;
    return ((c - 1) % SegLen) < Half;
  endfunction

  function automatic int exp_addr(input int c, input bit b_side);
    int s, k, span, g, j, a;
    s = (c - 1) / SegLen; k = (c - 1) % SegLen;
    span = N >> (s + 1); g = k / span; j = k % span;
    a = 2 * g * span + j;
    return b_side ? a + span : a;
  endfunction

  function automatic int exp_tw(input int c);
    int s, k, span;
    s = (c - 1) / SegLen; k = (c - 1) % SegLen; span = N >> (s + 1);
    return ((k % span) << s) % Half;
  endfunction

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r |= ((v >> i) & 1) << (LOG2N - 1 - i);
    return r;
  endfunction

  // ---------------- one full transform with per-cycle monitoring ----------------
  task automatic run_xform(input string tag, input int restart_cyc);
    int hist_a [0:DoneCyc+2];
    int hist_b [0:DoneCyc+2];
    int prev_re, prev_im, done_cyc, cnt_rd, cnt_wr;
    int e_busy, e_done, e_rd, e_wr, e_pipe, e_out;
    prev_re = 0; prev_im = 0; done_cyc = -1; cnt_rd = 0; cnt_wr = 0;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_pipe = 0; e_out = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= DoneCyc + 2; cyc++) begin
      @(negedge clk);
      hist_a[cyc] = int'(bus.rd_addr_a);
      hist_b[cyc] = int'(bus.rd_addr_b);
      if (bus.busy != (cyc < DoneCyc)) e_busy++;
      if (bus.done) begin
        if (done_cyc < 0) done_cyc = cyc;
        else e_done++;
      end
      if (bus.rd_en) cnt_rd++;
      if (bus.wr_en) cnt_wr++;
      if (exp_run(cyc)) begin
        if (!bus.rd_en || int'(bus.rd_addr_a) != exp_addr(cyc, 1'b0) ||
            int'(bus.rd_addr_b) != exp_addr(cyc, 1'b1) || int'(bus.tw_addr) != exp_tw(cyc))
          e_rd++;
      end
`ifdef FFT_BITREV_UNLOAD_EN
      else if (cyc > RunEnd && cyc <= RunEnd + N) begin
        if (!bus.rd_en || int'(bus.rd_addr_a) != brev(cyc - RunEnd - 1)) e_rd++;
      end
`endif
      else if (bus.rd_en) e_rd++;
`ifdef FFT_BITREV_UNLOAD_EN
      if (cyc > RunEnd + 1 && cyc <= DoneCyc) begin
        if (!bus.out_valid || int'(bus.out_idx) != cyc - RunEnd - 2) e_out++;
      end else if (bus.out_valid) e_out++;
`endif
      if (bus.wr_en != exp_run(cyc - 2)) e_wr++;
      if (cyc >= 3 && (int'(bus.wr_addr_a) != hist_a[cyc-2] ||
                       int'(bus.wr_addr_b) != hist_b[cyc-2])) e_pipe++;
      if (cyc >= 2 && (int'(bus.wr_a_re) != prev_re || int'(bus.wr_a_im) != prev_im)) e_pipe++;
      if (bus.wr_en && (bus.wr_b_re != bus.bf_xb_re || bus.wr_b_im != bus.bf_xb_im)) e_pipe++;
      prev_re = int'(bus.bf_xa_re);
      prev_im = int'(bus.bf_xa_im);
      case (cyc)
        1: begin
          check_eq({tag, " c1 rd_a"}, bus.rd_addr_a, 0);
          check_eq({tag, " c1 rd_b"}, bus.rd_addr_b, 16);
          check_eq({tag, " c1 tw"}, bus.tw_addr, 0);
        end
        2: begin
          check_eq({tag, " c2 rd_a"}, bus.rd_addr_a, 1);
          check_eq({tag, " c2 rd_b"}, bus.rd_addr_b, 17);
          check_eq({tag, " c2 tw"}, bus.tw_addr, 1);
        end
        17: begin
          check_eq({tag, " drain rd_en"}, bus.rd_en, 0);
          check_eq({tag, " drain wr_en"}, bus.wr_en, 1);
          check_eq({tag, " drain wr_a"}, bus.wr_addr_a, 14);
        end
        19: check_eq({tag, " s1k0 wr_en"}, bus.wr_en, 0);
        73: begin
          check_eq({tag, " s4k0 rd_a"}, bus.rd_addr_a, 0);
          check_eq({tag, " s4k0 rd_b"}, bus.rd_addr_b, 1);
        end
        74: begin
          check_eq({tag, " s4k1 rd_a"}, bus.rd_addr_a, 2);
          check_eq({tag, " s4k1 rd_b"}, bus.rd_addr_b, 3);
          check_eq({tag, " s4k1 tw"}, bus.tw_addr, 0);
        end
        88: begin
          check_eq({tag, " s4k15 rd_a"}, bus.rd_addr_a, 30);
          check_eq({tag, " s4k15 rd_b"}, bus.rd_addr_b, 31);
        end
        default: ;
      endcase
      if (cyc == restart_cyc) bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    check_eq({tag, " done cycle"}, done_cyc, DoneCyc);
    check_eq({tag, " extra done"}, e_done, 0);
    check_eq({tag, " busy cycles bad"}, e_busy, 0);
    check_eq({tag, " rd schedule bad"}, e_rd, 0);
    check_eq({tag, " wr_en schedule bad"}, e_wr, 0);
    check_eq({tag, " write alignment bad"}, e_pipe, 0);
    check_eq({tag, " out_valid/idx bad"}, e_out, 0);
    check_eq({tag, " rd_en count"}, cnt_rd, RdTotal);
    check_eq({tag, " wr_en count"}, cnt_wr, 80);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst busy", bus.busy, 0);
    check_eq("rst done", bus.done, 0);
    check_eq("rst rd_en", bus.rd_en, 0);
    check_eq("rst wr_en", bus.wr_en, 0);
    check_eq("rst rd_a", bus.rd_addr_a, 0);
    check_eq("rst rd_b", bus.rd_addr_b, 0);
    check_eq("rst tw", bus.tw_addr, 0);
    check_eq("rst wr_a", bus.wr_addr_a, 0);
    check_eq("rst wr_b", bus.wr_addr_b, 0);
    check_eq("rst wr_a_re", bus.wr_a_re, 0);
    check_eq("rst wr_b_re", bus.wr_b_re, 0);
`ifdef FFT_BITREV_UNLOAD_EN
    check_eq("rst out_valid", bus.out_valid, 0);
`endif
    rst = 1'b0;
    mem_init = 1'b0;

    // Impulse 1000+0j at x[0]: every DFT bin is 1000+0j; twiddle index 0 is exact unity
    run_xform("impulse", 0);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("bin%0d re", i), mem_re[brev(i)], 1000);
      check_eq($sformatf("bin%0d im", i), mem_im[brev(i)], 0);
    end

    // Start re-pulsed mid-run must be ignored
    run_xform("restart", 40);

    // Reset in cycle 50 aborts on that edge
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    check_eq("pre-abort busy", bus.busy, 1);
    check_eq("pre-abort wr_en", bus.wr_en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort busy", bus.busy, 0);
    check_eq("abort wr_en", bus.wr_en, 0);
    check_eq("abort rd_en", bus.rd_en, 0);
    check_eq("abort done", bus.done, 0);
    rst = 1'b0;

    run_xform("fresh", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
